// File: rtl/zbuf_fetch.sv
// Depth-buffer fetch stage: issues an Avalon-MM read of the stored depth for each
// fragment and re-joins the returned depth with the fragment, in order, for the z-test.
module zbuf_fetch #(
    parameter int                ADDR_W          = 26,
    parameter int                MAX_OUTSTANDING = 4,
    parameter logic [ADDR_W-1:0] DEPTH_OFFSET    = 26'h0800000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [ADDR_W-1:0] frag_addr,
    input  logic [31:0]       frag_depth,
    input  logic [31:0]       frag_color,
    input  logic              done_in,
    output logic              output_valid,
    input  logic              stall_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [31:0]       old_depth_out,
    output logic [31:0]       new_depth_out,
    output logic [31:0]       color_out,
    output logic              done_out,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic [3:0]        master_byteenable,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t MAX_CNT = cnt_t'(MAX_OUTSTANDING);

    logic              reset_q;
    cnt_t              occ;
    cnt_t              inflight;
    cnt_t              meta_cnt;
    cnt_t              resp_cnt;
    ptr_t              meta_wr;
    ptr_t              meta_rd;
    ptr_t              resp_wr;
    ptr_t              resp_rd;
    logic              done_latch;

    logic [ADDR_W-1:0] meta_addr_mem  [MAX_OUTSTANDING];
    logic [31:0]       meta_depth_mem [MAX_OUTSTANDING];
    logic [31:0]       meta_color_mem [MAX_OUTSTANDING];
    logic [31:0]       resp_mem       [MAX_OUTSTANDING];

    logic              accept;
    logic              issue;
    logic              rdv_ok;
    logic              transfer;
    logic              resp_nonempty;
    logic              load;
    logic              resp_push;
    logic              resp_pop;
    logic [31:0]       resp_head;

    assign master_byteenable = 4'b1111;
    assign frag_ready = ~reset_q & (occ < MAX_CNT) & ~(master_read & master_waitrequest);

    always_comb begin
        accept        = frag_valid & frag_ready;
        issue         = master_read & ~master_waitrequest;
        rdv_ok        = master_readdatavalid & (inflight != '0);
        transfer      = output_valid & ~stall_in;
        resp_nonempty = (resp_cnt != '0);
        load          = (resp_nonempty | rdv_ok) & (meta_cnt != '0) & (~output_valid | ~stall_in);
        // An empty response FIFO lets fresh read data go straight to the output register.
        resp_head     = resp_nonempty ? resp_mem[resp_rd] : master_readdata;
        resp_pop      = load & resp_nonempty;
        resp_push     = rdv_ok & ~(load & ~resp_nonempty);
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            meta_addr_mem[meta_wr]  <= frag_addr;
            meta_depth_mem[meta_wr] <= frag_depth;
            meta_color_mem[meta_wr] <= frag_color;
        end
        if (resp_push) begin
            resp_mem[resp_wr] <= master_readdata;
        end
    end

    always_ff @(posedge clock) begin
        reset_q <= reset;
        if (reset) begin
            occ            <= '0;
            inflight       <= '0;
            meta_cnt       <= '0;
            resp_cnt       <= '0;
            meta_wr        <= '0;
            meta_rd        <= '0;
            resp_wr        <= '0;
            resp_rd        <= '0;
            master_read    <= 1'b0;
            master_address <= '0;
            output_valid   <= 1'b0;
            addr_out       <= '0;
            old_depth_out  <= '0;
            new_depth_out  <= '0;
            color_out      <= '0;
            done_latch     <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            occ      <= occ + cnt_t'(accept) - cnt_t'(transfer);
            inflight <= inflight + cnt_t'(issue) - cnt_t'(rdv_ok);
            meta_cnt <= meta_cnt + cnt_t'(accept) - cnt_t'(load);
            resp_cnt <= resp_cnt + cnt_t'(resp_push) - cnt_t'(resp_pop);

            if (accept)    meta_wr <= meta_wr + ptr_t'(1);
            if (load)      meta_rd <= meta_rd + ptr_t'(1);
            if (resp_push) resp_wr <= resp_wr + ptr_t'(1);
            if (resp_pop)  resp_rd <= resp_rd + ptr_t'(1);

            if (accept) begin
                master_read    <= 1'b1;
                master_address <= frag_addr + DEPTH_OFFSET;
            end else if (issue) begin
                master_read    <= 1'b0;
            end

            if (load) begin
                output_valid  <= 1'b1;
                addr_out      <= meta_addr_mem[meta_rd];
                new_depth_out <= meta_depth_mem[meta_rd];
                color_out     <= meta_color_mem[meta_rd];
                old_depth_out <= resp_head;
            end else if (transfer) begin
                output_valid  <= 1'b0;
            end

            done_latch <= done_latch | done_in;
            done_out   <= done_out | (done_latch & (occ == '0) & ~output_valid & ~frag_valid);
        end
    end

endmodule

// File: doc/zbuf_fetch.md
Name: zbuf_fetch

Overview:
Pipeline stage directly upstream of the z-test stage. It accepts rasterized fragments (framebuffer address, new depth, colour) and issues Avalon-MM reads for each fragment's stored depth from the depth buffer. It re-joins each returned old depth with its fragment, in order, and presents {addr, old depth, new depth, colour} to the z-test. Up to MAX_OUTSTANDING reads are in flight, so memory latency is hidden and downstream stalls never lose read data.

Parameters:
ADDR_W, 26, width of framebuffer and Avalon byte addresses
MAX_OUTSTANDING, 4, maximum fragments accepted but not yet delivered downstream (power of 2, 2..16)
DEPTH_OFFSET, 26'h0800000, byte offset from a colour address to its depth word

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
frag_valid  in  1  upstream fragment valid
frag_ready  out  1  fragment accepted when frag_valid & frag_ready
frag_addr  in  26  framebuffer byte address of pixel
frag_depth  in  32  new (interpolated) depth
frag_color  in  32  pixel colour
done_in  in  1  end-of-frame marker from rasterizer (level or pulse)
output_valid  out  1  fragment valid to z-test
stall_in  in  1  z-test back-pressure; transfer when output_valid & !stall_in
addr_out  out  26  fragment address
old_depth_out  out  32  depth read from depth buffer
new_depth_out  out  32  fragment depth
color_out  out  32  fragment colour
done_out  out  1  frame complete, all fragments delivered
master_address  out  26  Avalon read address
master_read  out  1  Avalon read request
master_byteenable  out  4  always 4'b1111
master_readdata  in  32  read data
master_readdatavalid  in  1  read data valid
master_waitrequest  in  1  slave not ready

Behaviour:
- Reset (sync, high): frag_ready=0, output_valid=0, master_read=0, done_out=0, master_address=0, all data outputs=0, FIFOs and counters cleared, done latch cleared.
- Occupancy counter `occ` counts fragments accepted and not yet transferred downstream. Range 0..MAX_OUTSTANDING.
- frag_ready = !reset_q & (occ < MAX_OUTSTANDING) & !(master_read & master_waitrequest). It is a combinational function of registered state.
- Accept at cycle T:
  - Push {addr, depth, colour} into the meta FIFO (depth MAX_OUTSTANDING).
  - At T+1, master_read=1 and master_address = frag_addr + DEPTH_OFFSET, truncated mod 2^26 (wraps, no error).
- Avalon read handshake:
  - master_read and master_address are held stable while master_waitrequest=1.
  - The read is issued in the first cycle with waitrequest=0.
  - master_read deasserts the next cycle unless a new fragment was accepted, which gives back-to-back reads of 1 per cycle.
- Response: each master_readdatavalid pushes master_readdata into the response FIFO (depth MAX_OUTSTANDING). The occ limit guarantees it never overflows.
- A readdatavalid with no outstanding read (in-flight count 0) is discarded; no state changes.
- Output register:
  - When response FIFO and meta FIFO are both non-empty, and the output register is empty or being transferred this cycle, pop both heads into the output register.
  - output_valid=1 the next cycle.
  - Minimum latency, accept to output_valid, is 3 cycles with 1-cycle read latency and waitrequest=0.
- While output_valid & stall_in, all output data is held unchanged. A transfer decrements occ, and the decrement may coincide with an accept (occ unchanged).
- Ordering is strictly in order; responses are assumed in order per Avalon.
- done: done_in=1 sets a sticky latch. done_out=1 (registered) when latch=1 & occ=0 & !output_valid & !frag_valid. It holds until reset.
- Full boundary: at occ=MAX_OUTSTANDING, frag_ready=0 until a downstream transfer. Frag_ready rises in the same cycle as the transfer's register update (next cycle).
- Reset mid-operation: all in-flight state is dropped; the interconnect is reset together with this block.

Test Plan:
- Single fragment (addr 26'h000100, depth 32'h10, colour 32'hFF0000), read latency 1, waitrequest=0 -> master_address=26'h0800100 at T+1; output_valid at T+3 with old_depth = returned data 32'h20 and all fields echoed.
- waitrequest held high 5 cycles -> master_read and master_address stable for 6 cycles; frag_ready=0 throughout; a single read issued.
- 8 back-to-back fragments, read latency 4, stall_in=0 -> at most 4 outstanding; frag_ready drops at occ=4; outputs appear in order with matching depths; no loss.
- stall_in=1 for 10 cycles with 4 reads returned -> output data frozen, response FIFO holds 3; after release, 4 transfers in 4 consecutive cycles.
- done_in pulse while 3 fragments in flight -> done_out stays 0 until last transfer, rises 1 cycle after occ=0, stays 1; reset -> done_out=0.
- frag_addr 26'h3FFFFF0 -> master_address = 26'h07FFFF0 (wrap); reset asserted mid-burst -> next cycle master_read=0, output_valid=0, frag_ready=0.
